// File: rtl/character_pkg.sv
// ============================================================================
// Module      : character_pkg
// Description : Shared types and constants for the character sprite path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package character_pkg;

    localparam int CHAR_W = 5;
    localparam int CHAR_H = 9;

    // Coordinate widths shared with the character position decoder
    localparam int X_W = 8;
    localparam int Y_W = 7;

    localparam logic [2:0] COLOUR_FG = 3'b111;
    localparam logic [2:0] COLOUR_BG = 3'b000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ERASE  = 2'd1,
        DRAW   = 2'd2,
        FINISH = 2'd3
    } plot_state_e;

endpackage

`default_nettype wire

// File: rtl/rect_scan_counter.sv
// ============================================================================
// Module      : rect_scan_counter
// Description : Raster col/row counter over a WIDTH x HEIGHT rectangle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rect_scan_counter
    import character_pkg::*;
#(
    parameter int WIDTH  = CHAR_W,
    parameter int HEIGHT = CHAR_H,
    parameter int COL_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1,
    parameter int ROW_W  = (HEIGHT > 1) ? $clog2(HEIGHT) : 1
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             clear_i,
    input  logic             enable_i,
    output logic [COL_W-1:0] col_o,
    output logic [ROW_W-1:0] row_o,
    output logic             last_o
);

    localparam logic [COL_W-1:0] COL_MAX = COL_W'(WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(HEIGHT - 1);

    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;

    assign col_o  = col_q;
    assign row_o  = row_q;
    assign last_o = (col_q == COL_MAX) && (row_q == ROW_MAX);

    // Wrapping on the last pixel leaves the counter at (0,0) for the next scan
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (clear_i) begin
            col_d = '0;
            row_d = '0;
        end else if (enable_i) begin
            if (col_q == COL_MAX) begin
                col_d = '0;
                row_d = (row_q == ROW_MAX) ? '0 : row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/character_plotter.sv
// ============================================================================
// Module      : character_plotter
// Description : Erases the sprite at its old position and redraws it at the new one.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module character_plotter
    import character_pkg::*;
#(
    parameter int         WIDTH     = CHAR_W,
    parameter int         HEIGHT    = CHAR_H,
    parameter logic [2:0] FG_COLOUR = COLOUR_FG,
    parameter logic [2:0] BG_COLOUR = COLOUR_BG,
    parameter int         SCREEN_W  = 160,
    parameter int         SCREEN_H  = 120
) (
    input  logic           Clock,
    input  logic           Reset,
    input  logic [X_W-1:0] XIn,
    input  logic [Y_W-1:0] YIn,
    output logic [X_W-1:0] XPix,
    output logic [Y_W-1:0] YPix,
    output logic [2:0]     ColourOut,
    output logic           Plot,
    output logic           Busy,
    output logic           Done
);

    localparam int COL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int XS_W  = X_W + 1;
    localparam int YS_W  = Y_W + 1;

    localparam logic [XS_W-1:0] X_LIMIT = XS_W'(SCREEN_W);
    localparam logic [YS_W-1:0] Y_LIMIT = YS_W'(SCREEN_H);

    plot_state_e    state_q, state_d;
    logic [X_W-1:0] old_x_q, old_x_d, new_x_q, new_x_d;
    logic [Y_W-1:0] old_y_q, old_y_d, new_y_q, new_y_d;
    logic           valid_q, valid_d;
    logic [X_W-1:0] xpix_q, xpix_d;
    logic [Y_W-1:0] ypix_q, ypix_d;
    logic [2:0]     colour_q, colour_d;
    logic           plot_q, plot_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    logic [COL_W-1:0] w_col;
    logic [ROW_W-1:0] w_row;
    logic             w_last;
    logic             w_scan_clr;
    logic             w_scan_en;
    logic [X_W-1:0]   w_base_x;
    logic [Y_W-1:0]   w_base_y;
    logic [XS_W-1:0]  w_x_sum;
    logic [YS_W-1:0]  w_y_sum;
    logic             w_on_screen;
    logic             w_change;

    rect_scan_counter #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT),
        .COL_W  (COL_W),
        .ROW_W  (ROW_W)
    ) u_scan (
        .Clock    (Clock),
        .Reset    (Reset),
        .clear_i  (w_scan_clr),
        .enable_i (w_scan_en),
        .col_o    (w_col),
        .row_o    (w_row),
        .last_o   (w_last)
    );

    assign w_base_x    = (state_q == ERASE) ? old_x_q : new_x_q;
    assign w_base_y    = (state_q == ERASE) ? old_y_q : new_y_q;
    assign w_x_sum     = {1'b0, w_base_x} + XS_W'(w_col);
    assign w_y_sum     = {1'b0, w_base_y} + YS_W'(w_row);
    assign w_on_screen = (w_x_sum < X_LIMIT) && (w_y_sum < Y_LIMIT);

    // Done_q blocks detection so the next sequence starts no earlier than the cycle after Done
    assign w_change = !done_q && (!valid_q || ({XIn, YIn} != {old_x_q, old_y_q}));

    always_comb begin
        state_d    = state_q;
        old_x_d    = old_x_q;
        old_y_d    = old_y_q;
        new_x_d    = new_x_q;
        new_y_d    = new_y_q;
        valid_d    = valid_q;
        xpix_d     = xpix_q;
        ypix_d     = ypix_q;
        colour_d   = colour_q;
        plot_d     = 1'b0;
        busy_d     = busy_q;
        done_d     = 1'b0;
        w_scan_clr = 1'b0;
        w_scan_en  = 1'b0;

        case (state_q)
            IDLE: begin
                if (w_change) begin
                    new_x_d    = XIn;
                    new_y_d    = YIn;
                    w_scan_clr = 1'b1;
                    busy_d     = 1'b1;
                    state_d    = valid_q ? ERASE : DRAW;
                end
            end
            ERASE, DRAW: begin
                w_scan_en = 1'b1;
                xpix_d    = w_x_sum[X_W-1:0];
                ypix_d    = w_y_sum[Y_W-1:0];
                colour_d  = (state_q == ERASE) ? BG_COLOUR : FG_COLOUR;
                plot_d    = w_on_screen;
                if (w_last) begin
                    state_d = (state_q == ERASE) ? DRAW : FINISH;
                end
            end
            FINISH: begin
                old_x_d = new_x_q;
                old_y_d = new_y_q;
                valid_d = 1'b1;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q  <= IDLE;
            old_x_q  <= '0;
            old_y_q  <= '0;
            new_x_q  <= '0;
            new_y_q  <= '0;
            valid_q  <= 1'b0;
            xpix_q   <= '0;
            ypix_q   <= '0;
            colour_q <= '0;
            plot_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            old_x_q  <= old_x_d;
            old_y_q  <= old_y_d;
            new_x_q  <= new_x_d;
            new_y_q  <= new_y_d;
            valid_q  <= valid_d;
            xpix_q   <= xpix_d;
            ypix_q   <= ypix_d;
            colour_q <= colour_d;
            plot_q   <= plot_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign XPix      = xpix_q;
    assign YPix      = ypix_q;
    assign ColourOut = colour_q;
    assign Plot      = plot_q;
    assign Busy      = busy_q;
    assign Done      = done_q;

endmodule

`default_nettype wire

// File: tb/tb_character_plotter.sv
// ============================================================================
// Module      : tb_character_plotter
// Description : Directed self-checking bench for character_plotter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_character_plotter;

    localparam int W = 5;
    localparam int H = 9;

    typedef struct packed {
        int         cyc;
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } pix_t;

    logic       Clock;
    logic       Reset;
    logic [7:0] XIn;
    logic [6:0] YIn;
    logic [7:0] XPix;
    logic [6:0] YPix;
    logic [2:0] ColourOut;
    logic       Plot;
    logic       Busy;
    logic       Done;

    int   cyc;
    int   checks;
    int   errors;
    pix_t pix_q[$];
    int   done_cyc_q[$];

    character_plotter dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .XIn       (XIn),
        .YIn       (YIn),
        .XPix      (XPix),
        .YPix      (YPix),
        .ColourOut (ColourOut),
        .Plot      (Plot),
        .Busy      (Busy),
        .Done      (Done)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    initial cyc = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    always @(negedge Clock) begin
        if (Plot === 1'b1) pix_q.push_back('{cyc: cyc, x: XPix, y: YPix, c: ColourOut});
        if (Done === 1'b1) done_cyc_q.push_back(cyc);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check_eq({tag, "_out"}, {24'd0, Plot, Busy, Done, ColourOut}, 32'd0);
        check_eq({tag, "_pix"}, {17'd0, XPix, YPix}, 32'd0);
    endtask

    task automatic apply(input int x, input int y, output int n);
        @(posedge Clock);
        #1;
        XIn = 8'(x);
        YIn = 7'(y);
        n   = cyc;
    endtask

    // Waits for Done after detection cycle n, then checks timing and every plotted pixel
    task automatic seq_check(input int n, input bit erase, input int ox, input int oy,
                             input int nx, input int ny);
        int   busy_low;
        int   px, py, base;
        pix_t e, p;
        pix_t exp_q[$];
        busy_low = 0;
        while (done_cyc_q.size() == 0 && cyc < n + 200) begin
            @(negedge Clock);
            #1;
            if (cyc == n + 1) check_eq("busy_rise", {31'd0, Busy}, 32'd1);
            if (cyc > n && Done !== 1'b1 && Busy !== 1'b1) busy_low++;
            if (Done === 1'b1) check_eq("busy_fall", {31'd0, Busy}, 32'd0);
        end
        check_eq("done_seen", done_cyc_q.size(), 1);
        if (done_cyc_q.size() == 0) return;
        check_eq("done_cyc", done_cyc_q.pop_front(), n + (erase ? 92 : 47));
        check_eq("busy_gap", busy_low, 0);

        for (int ph = (erase ? 0 : 1); ph < 2; ph++) begin
            base = n + 2 + (erase && ph == 1 ? W * H : 0);
            for (int i = 0; i < W * H; i++) begin
                px = (ph == 0 ? ox : nx) + i % W;
                py = (ph == 0 ? oy : ny) + i / W;
                if (px < 160 && py < 120) begin
                    e.cyc = base + i;
                    e.x   = 8'(px);
                    e.y   = 7'(py);
                    e.c   = (ph == 0) ? 3'b000 : 3'b111;
                    exp_q.push_back(e);
                end
            end
        end
        check_eq("npix", pix_q.size(), exp_q.size());
        foreach (exp_q[i]) begin
            if (pix_q.size() == 0) break;
            p = pix_q.pop_front();
            check_eq("pix_cyc", p.cyc, exp_q[i].cyc);
            check_eq("pix_xyc", {14'd0, p.x, p.y, p.c}, {14'd0, exp_q[i].x, exp_q[i].y, exp_q[i].c});
        end

        @(negedge Clock);
        #1;
        check_eq("done_pulse", {31'd0, Done}, 32'd0);
        check_eq("busy_after", {31'd0, Busy}, 32'd0);
    endtask

    int n;
    int n2;
    int noisy;

    initial begin
        checks = 0;
        errors = 0;
        Reset  = 1'b0;
        XIn    = 8'd78;
        YIn    = 7'd7;

        // Reset, then draw-only at (78,7)
        repeat (3) @(posedge Clock);
        #1;
        check_zero_outputs("reset");
        Reset = 1'b1;
        n     = cyc;
        pix_q.delete();
        done_cyc_q.delete();
        seq_check(n, 1'b0, 0, 0, 78, 7);

        // Move to (96,7): erase then draw
        apply(96, 7, n);
        seq_check(n, 1'b1, 78, 7, 96, 7);

        // Unchanged input stays quiet
        noisy = 0;
        repeat (200) begin
            @(negedge Clock);
            #1;
            if (Plot !== 1'b0 || Busy !== 1'b0) noisy++;
        end
        check_eq("idle_quiet", noisy, 0);
        check_eq("idle_nopix", pix_q.size(), 0);

        // Input changes during DRAW are deferred to the next sequence
        apply(96, 30, n);
        fork
            begin
                repeat (50) @(posedge Clock);
                #1;
                XIn = 8'd114;
                repeat (10) @(posedge Clock);
                #1;
                XIn = 8'd132;
            end
        join_none
        seq_check(n, 1'b1, 96, 7, 96, 30);
        n2 = n + 93;
        seq_check(n2, 1'b1, 96, 30, 132, 30);

        // Reset mid-erase, next sequence is draw-only
        apply(20, 50, n);
        repeat (10) @(posedge Clock);
        #1;
        Reset = 1'b0;
        @(posedge Clock);
        #1;
        Reset = 1'b1;
        n     = cyc;
        @(negedge Clock);
        #1;
        check_zero_outputs("midreset");
        pix_q.delete();
        done_cyc_q.delete();
        seq_check(n, 1'b0, 0, 0, 20, 50);

        // Bottom-right corner clipping after a fresh reset
        @(posedge Clock);
        #1;
        Reset = 1'b0;
        XIn   = 8'd158;
        YIn   = 7'd115;
        @(posedge Clock);
        #1;
        Reset = 1'b1;
        n     = cyc;
        pix_q.delete();
        done_cyc_q.delete();
        seq_check(n, 1'b0, 0, 0, 158, 115);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/character_plotter.md
# character_plotter

Pixel-rendering stage directly downstream of the character position decoder. It takes the character's top-left coordinate (XIn/YIn) and, whenever that coordinate changes, erases the 5×9 rectangle at the previously drawn position and draws it at the new one. It emits one pixel per clock to the VGA adapter's x/y/colour/plot inputs. It owns all frame-buffer writes for the character sprite.

## Interface
- WIDTH, 5: character width in pixels
- HEIGHT, 9: character height in pixels
- FG_COLOUR, 3'b111: draw colour
- BG_COLOUR, 3'b000: erase colour
- SCREEN_W, 160: visible columns; pixels with x ≥ SCREEN_W are not plotted
- SCREEN_H, 120: visible rows; pixels with y ≥ SCREEN_H are not plotted
- Clock  in  1  system clock, all logic on rising edge
- Reset  in  1  synchronous, active-low
- XIn  in  8  top-left x of the requested character position
- YIn  in  7  top-left y of the requested character position
- XPix  out  8  pixel x to the adapter
- YPix  out  7  pixel y to the adapter
- ColourOut  out  3  pixel colour
- Plot  out  1  write-enable for the current pixel
- Busy  out  1  an erase or draw sequence is in progress
- Done  out  1  one-cycle pulse when a sequence finishes

## Operation
- Internal state: OldX/OldY (last drawn position), NewX/NewY (position being drawn), Valid (OldX/OldY holds a drawn sprite), col counter 0..WIDTH-1, row counter 0..HEIGHT-1.
- FSM states: IDLE, ERASE, DRAW, FINISH.
- IDLE: each cycle, compare {XIn,YIn} with {OldX,OldY}.
  - If Valid=0, or the values differ, latch NewX/NewY and clear the counters.
  - Go to ERASE if Valid=1, else go to DRAW.
  - If Valid=1 and the values are equal, stay in IDLE and keep Plot=0.
- ERASE: scan the rectangle at OldX/OldY with BG_COLOUR.
- DRAW: scan the rectangle at NewX/NewY with FG_COLOUR.
- Scan order is raster: col increments every cycle. On col=WIDTH-1, col wraps to 0 and row increments. The cycle with col=WIDTH-1 and row=HEIGHT-1 is the last pixel of the state.
- ERASE→DRAW transition: occurs after the last erase pixel; counters reset to 0.
- DRAW→FINISH transition: occurs after the last draw pixel. In FINISH, OldX/OldY ← NewX/NewY, Valid ← 1, then return to IDLE.
- Pixel coordinates:
  - XPix = base x + col, computed 9 bits wide.
  - YPix = base y + row, computed 8 bits wide.
  - Plot = 0 for any pixel whose full-width sum is ≥ SCREEN_W or ≥ SCREEN_H. That pixel's cycle is still consumed, so scan length is fixed.
- XIn/YIn changes while Busy=1 are ignored. After FINISH, IDLE re-compares, so the most recent position is always drawn eventually.
- Reset (Reset=0 at an edge), from any state including mid-scan:
  - state ← IDLE; Valid ← 0; counters ← 0.
  - Plot, Busy, Done ← 0; XPix, YPix, ColourOut ← 0.
  - The next sequence is a draw with no erase. Clearing stale pixels after reset is the screen-clear block's responsibility.

## Timing
- All outputs are registered.
- Outputs for pixel k of a state appear one cycle after the counter holds k.
- Let N be the IDLE cycle that detects a change. Then:
  - Busy = 1 from cycle N+1.
  - The first pixel is on the outputs at N+2.
  - With erase: Plot is high for WIDTH·HEIGHT (45) erase cycles, immediately followed by 45 draw cycles, with no gap (90 contiguous cycles, minus off-screen pixels).
  - Without erase: 45 contiguous draw cycles.
- Done pulses for one cycle, in the cycle after the last pixel. Busy falls in that same cycle.
- The earliest next detection is the cycle after Done.
- Sequence cost: 92 cycles with erase, 47 without, from detection to Done.

## Structure
- Shared package `character_pkg`:
  - FSM state enum (IDLE, ERASE, DRAW, FINISH).
  - CHAR_W=5, CHAR_H=9.
  - Colour constants.
  - Position-decoder coordinate widths (X 8 bits, Y 7 bits), also used by the position decoder.
- Sub-module `rect_scan_counter`: col/row counter with clear, enable and a `last` flag at (WIDTH-1, HEIGHT-1). It is instantiated once and shared by ERASE and DRAW.

## Test plan
- Reset, then hold XIn=78, YIn=7 → 45 Plot cycles covering x=78..82, y=7..15 in raster order, all ColourOut=3'b111, no BG pixels; Done pulses once; Busy=0 afterward.
- From the drawn state at 78, set XIn=96 → 45 BG pixels at x=78..82, y=7..15, then 45 FG pixels at x=96..100 contiguously; first pixel at N+2; Done at N+92.
- Hold XIn=96 after Done for 200 cycles → Plot stays 0, Busy stays 0.
- During DRAW of 96, change XIn to 114 then 132 → the current sequence completes at 96 unaltered; the next sequence erases 96 and draws 132.
- Assert Reset=0 for one cycle mid-ERASE → on the next cycle Plot=0, Busy=0, Done=0, all outputs 0; the following change produces a draw-only sequence of 45 pixels with no erase.
- XIn=158, YIn=115 → only x=158..159 with y=115..119 are plotted (10 Plot cycles); the scan still takes 45 cycles; Done at N+47.
